// File: rtl/fc_argmax10.sv
// fc_argmax10 - final argmax over the ten Float8 class scores of the last
// fully-connected layer. One score comparison per cycle. Latency from the
// accepted start edge to done is 10 cycles when ena is held high.
//
// Ports:
//   clk     - clock, rising edge
//   iRst_n  - asynchronous active-low reset
//   ena     - clock enable; low holds every flop, including the scan position
//   start   - single-cycle request, honoured only in IDLE or DONE
//   scores  - packed scores, class k at scores[8k+7:8k] (sign/magnitude Float8)
//   pred    - index of the winning class (valid while done)
//   best    - Float8 value of the winning score (valid while done)
//   busy    - high in LOAD and SCAN
//   done    - high in DONE
//
// Build option: FC_ARGMAX_RELU_EN clamps every negative score to 0x00 at LOAD.
//
//  state | meaning
//  IDLE  | after reset, waiting for start
//  LOAD  | snapshot scores, seed best/pred with class 0
//  SCAN  | compare class idx against best, one class per cycle
//  DONE  | results held, start re-enters LOAD
module fc_argmax10 #(
   parameter int N_CLASS = 10,
   parameter int IDX_W   = 4
) (
   input  logic                   clk,
   input  logic                   iRst_n,
   input  logic                   ena,
   input  logic                   start,
   input  logic [8*N_CLASS-1:0]   scores,
   output logic [IDX_W-1:0]       pred,
   output logic [7:0]             best,
   output logic                   busy,
   output logic                   done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_SCAN = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [IDX_W-1:0] pred_q,  pred_d;
   logic [7:0]       best_q,  best_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic [7:0]       score_q [N_CLASS];
   logic [7:0]       score_d [N_CLASS];
   logic [7:0]       cur_score;

   function automatic logic [7:0] clamp_score(input logic [7:0] v);
`ifdef FC_ARGMAX_RELU_EN
      return v[7] ? 8'h00 : v;
`else
      return v;
`endif
   endfunction

   // Maps sign/magnitude onto an unsigned order: positives above negatives,
   // negative magnitudes inverted, and -0 folded onto +0 so they tie.
   function automatic logic [7:0] order_key(input logic [7:0] v);
      logic [7:0] n;
      n = (v == 8'h80) ? 8'h00 : v;
      return n[7] ? {1'b0, ~n[6:0]} : {1'b1, n[6:0]};
   endfunction

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pred_d    = pred_q;
      best_d    = best_q;
      busy_d    = busy_q;
      done_d    = done_q;
      score_d   = score_q;
      cur_score = score_q[idx_q];
      if (ena) begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d = S_LOAD;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
               end
            end
            S_LOAD: begin
               for (int k = 0; k < N_CLASS; k++) begin
                  score_d[k] = clamp_score(scores[8*k +: 8]);
               end
               best_d  = clamp_score(scores[7:0]);
               pred_d  = '0;
               idx_d   = IDX_W'(1);
               state_d = S_SCAN;
            end
            S_SCAN: begin
               // strict compare: on a tie the earlier class keeps the win
               if (order_key(cur_score) > order_key(best_q)) begin
                  best_d = cur_score;
                  pred_d = idx_q;
               end
               if (idx_q == IDX_W'(N_CLASS - 1)) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         pred_q  <= '0;
         best_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int k = 0; k < N_CLASS; k++) begin
            score_q[k] <= 8'h00;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pred_q  <= pred_d;
         best_q  <= best_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         score_q <= score_d;
      end
   end

   assign pred = pred_q;
   assign best = best_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_fc_argmax10.sv
// Self-checking bench for fc_argmax10: a cycle-level behavioural model built
// from the argmax rules (signed magnitude values, lowest index on a tie) is
// compared against the DUT every cycle, plus literal expectations per case.
module tb_fc_argmax10;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        ena    = 1'b1;
   logic        start  = 1'b0;
   logic [79:0] scores = '0;
   logic [3:0]  pred;
   logic [7:0]  best;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   fc_argmax10 dut (
      .clk    (clk),
      .iRst_n (rst_n),
      .ena    (ena),
      .start  (start),
      .scores (scores),
      .pred   (pred),
      .best   (best),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef FC_ARGMAX_RELU_EN
      return v[7] ? 8'h00 : v;
`else
      return v;
`endif
   endfunction

   function automatic int sval(input logic [7:0] v);
      return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
   endfunction

   logic [7:0] m_snap [10];
   bit         m_busy = 0;
   bit         m_done = 0;
   int         m_cnt  = 0;
   logic [3:0] m_pred = '0;
   logic [7:0] m_best = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_cnt = 0; m_pred = '0; m_best = '0;
      end else if (ena) begin
         if (m_busy) begin
            m_cnt++;
            if (m_cnt == 1) begin
               for (int k = 0; k < 10; k++) m_snap[k] = relu(scores[8*k +: 8]);
            end
            if (m_cnt == 10) begin
               int bv;
               m_pred = 0;
               m_best = m_snap[0];
               bv     = sval(m_snap[0]);
               for (int k = 1; k < 10; k++) begin
                  if (sval(m_snap[k]) > bv) begin
                     bv = sval(m_snap[k]); m_pred = 4'(k); m_best = m_snap[k];
                  end
               end
               m_busy = 0;
               m_done = 1;
            end
         end else if (start) begin
            m_busy = 1; m_done = 0; m_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      if (!m_busy) begin
         chk("pred", 32'(pred), 32'(m_pred));
         chk("best", 32'(best), 32'(m_best));
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [79:0] fill(input logic [7:0] base, input int i0,
                                        input logic [7:0] v0, input int i1,
                                        input logic [7:0] v1);
      logic [79:0] s;
      for (int k = 0; k < 10; k++) s[8*k +: 8] = base;
      if (i0 >= 0) s[8*i0 +: 8] = v0;
      if (i1 >= 0) s[8*i1 +: 8] = v1;
      return s;
   endfunction

   task automatic run(input logic [79:0] sc, input int hold_at, input int restart_at,
                      input bit scramble, input bit rand_ena, output int n);
      logic [95:0] junk;
      ena    = 1'b1;
      scores = sc;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         if (scramble && m_cnt >= 1) begin
            junk   = {$urandom, $urandom, $urandom};
            scores = junk[79:0];
         end
         if (rand_ena) ena = ($urandom_range(3) != 0);
         else          ena = !(n >= hold_at && n < hold_at + 3);
         start = (n == restart_at);
         @(posedge clk); #1;
         n++;
      end
      ena   = 1'b1;
      start = 1'b0;
      if (n >= 200) chk("done_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      int n;
      logic [79:0] sc;
      logic [3:0]  e_pred;
      logic [7:0]  e_best;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pred", 32'(pred), 32'h0);
      chk("rst_best", 32'(best), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single winner, exact latency
      run(fill(8'h30, 3, 8'h48, -1, 8'h00), 1000, -1, 0, 0, n);
      chk("single_lat",  32'(n),    32'd10);
      chk("single_pred", 32'(pred), 32'd3);
      chk("single_best", 32'(best), 32'h48);

      // tie: lowest index wins
      run(fill(8'h10, 2, 8'h50, 7, 8'h50), 1000, -1, 0, 0, n);
      chk("tie_pred", 32'(pred), 32'd2);
      chk("tie_best", 32'(best), 32'h50);

      // all negative
      run(fill(8'hC0, 5, 8'h81, -1, 8'h00), 1000, -1, 0, 0, n);
`ifdef FC_ARGMAX_RELU_EN
      e_pred = 4'd0; e_best = 8'h00;
`else
      e_pred = 4'd5; e_best = 8'h81;
`endif
      chk("neg_pred", 32'(pred), 32'(e_pred));
      chk("neg_best", 32'(best), 32'(e_best));

      // signed zero: -0 and +0 tie
      run(fill(8'h85, 0, 8'h80, 1, 8'h00), 1000, -1, 0, 0, n);
`ifdef FC_ARGMAX_RELU_EN
      e_best = 8'h00;
`else
      e_best = 8'h80;
`endif
      chk("zero_pred", 32'(pred), 32'd0);
      chk("zero_best", 32'(best), 32'(e_best));

      // ena low 3 cycles mid-scan
      run(fill(8'h20, 8, 8'h7F, -1, 8'h00), 4, -1, 0, 0, n);
      chk("hold_lat",  32'(n),    32'd13);
      chk("hold_pred", 32'(pred), 32'd8);
      chk("hold_best", 32'(best), 32'h7F);

      // start re-pulsed during SCAN and scores scrambled after LOAD
      run(fill(8'h11, 6, 8'h3C, 9, 8'h3B), 1000, 3, 1, 0, n);
      chk("intf_lat",  32'(n),    32'd10);
      chk("intf_pred", 32'(pred), 32'd6);
      chk("intf_best", 32'(best), 32'h3C);

      // reset at cycle 5 of a scan
      scores = fill(8'h05, 4, 8'h66, -1, 8'h00);
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("midrst_pred", 32'(pred), 32'h0);
      chk("midrst_best", 32'(best), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_done", 32'(done), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(fill(8'h05, 4, 8'h66, -1, 8'h00), 1000, -1, 0, 0, n);
      chk("postrst_lat",  32'(n),    32'd10);
      chk("postrst_pred", 32'(pred), 32'd4);
      chk("postrst_best", 32'(best), 32'h66);

      // randomized scores with random ena gaps, checked by the model
      for (int r = 0; r < 40; r++) begin
         for (int k = 0; k < 10; k++) begin
            case ($urandom_range(5))
               0:       sc[8*k +: 8] = 8'h00;
               1:       sc[8*k +: 8] = 8'h80;
               2:       sc[8*k +: 8] = 8'h42;
               default: sc[8*k +: 8] = 8'($urandom);
            endcase
         end
         run(sc, 1000, -1, (r % 2) == 1, (r % 3) == 0, n);
         repeat ($urandom_range(2)) begin @(posedge clk); #1; end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fc_argmax10.md
# fc_argmax10

Final classification stage of the digit-recognition datapath. Sits directly downstream of the last fully-connected layer and consumes its packed 10 × Float8 `result` vector. Scans the ten class scores sequentially with one comparison per cycle. Reports the winning digit (0–9), its score, and a `done` flag to the display/output logic.

## Interface
Parameters:
- `N_CLASS`, default 10: number of scores; the design is verified only at 10.
- `IDX_W`, default 4: width of the class index.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `iRst_n`, input, 1: asynchronous, active-low reset.
- `ena`, input, 1: when low, all state and outputs hold (clock-enable semantics, no high-Z).
- `start`, input, 1: single-cycle request; sampled only in IDLE or DONE.
- `scores`, input, 80: class k occupies `scores[8k+7:8k]`, Float8 encoding.
- `pred`, output, 4: index of the maximum score.
- `best`, output, 8: Float8 value of the winning score.
- `busy`, output, 1: high in LOAD/SCAN.
- `done`, output, 1: high while in DONE; `pred` and `best` are valid.

## Operation
- Float8 encoding: bit 7 is the sign, bits 6:0 are the magnitude (exponent and mantissa, biased, monotonic). The block only orders values; it never does arithmetic on them.
- Ordering key: `0x80` (−0) is first normalised to `0x00`.
  - Positive values map to key = {1'b1, mag}.
  - Negative values map to key = {1'b0, ~mag}.
  - a > b if and only if key(a) > key(b), using an unsigned 8-bit compare.
- Tie rule: strict greater-than only, so the lowest index wins.
- States:
  - IDLE: wait for `start`.
  - LOAD: latch `scores` into an internal register. Set best = score0, pred = 0, i = 1.
  - SCAN: each cycle, if key(score_i) > key(best), set best = score_i and pred = i. Then i = i + 1. Leave SCAN after i = 9 has been evaluated.
  - DONE: hold the results. `start` here re-enters LOAD.
- The internal score register isolates the block from upstream changes. `scores` may change at any time after the LOAD edge.
- `start` is ignored while `busy` is high.
- Reset values: state IDLE, `pred` = 0, `best` = 0x00, `busy` = 0, `done` = 0, i = 0. Reset asserted mid-scan aborts immediately to these values.
- While `ena` is low, `start` is not sampled and the scan does not advance. The scan resumes exactly where it stopped.

## Timing
- Edge E0: `start` = 1 is sampled in IDLE or DONE. The state moves to LOAD, and `done` falls at E0.
- E1: the LOAD work is performed and the state moves to SCAN. `busy` is high from E0 to E10.
- E2–E10: nine SCAN evaluations for i = 1..9.
- E10: the final update, the state moves to DONE, and `done` = 1.
- Total latency from the `start` edge to `done` high is 10 cycles, assuming `ena` is held high.
- `done` stays high until the next accepted `start` or a reset.
- `pred` and `best` may change during SCAN. They are only valid while `done` = 1.

## Configuration
- `FC_ARGMAX_RELU_EN` defined: each score is clamped at LOAD. Any value with sign = 1 becomes 0x00. As a result:
  - `best` is never negative.
  - If all ten scores are negative, the result is `pred` = 0 with `best` = 0x00.
- Not defined: signed ordering is used exactly as described under Operation.

## Test plan
- Single winner: score3 = 0x48, all others 0x30, pulse `start`. Expect `done` after exactly 10 cycles, `pred` = 3, `best` = 0x48.
- Tie, lowest index wins: score2 = score7 = 0x50, all others 0x10. Expect `pred` = 2, `best` = 0x50.
- All negative, without the macro: score5 = 0x81, all others 0xC0. Expect `pred` = 5, `best` = 0x81. With `FC_ARGMAX_RELU_EN` defined, expect `pred` = 0, `best` = 0x00.
- Signed zero: score0 = 0x80, score1 = 0x00, all others 0x85. Expect `pred` = 0 (the two zeros compare equal) and `best` = 0x80. With the macro defined, `best` = 0x00.
- Control interference:
  - Hold `ena` = 0 for 3 cycles mid-scan. Expect `done` to be delayed by exactly 3 cycles with an unchanged `pred`.
  - Re-pulse `start` during SCAN. Expect it to be ignored.
  - Change `scores` after LOAD. Expect no effect on the result.
- Reset mid-scan: assert `iRst_n` = 0 at cycle 5 after `start`. Expect all outputs 0 immediately. After release, a new `start` completes normally with correct `pred` and `best`.
